// File: rtl/ysyx_22050243_lsu.sv
// RV64 load/store unit: one request at a time, IDLE -> ACCESS -> RESP handshake
// with byte-lane alignment of store data and sign/zero extension of load data.
module ysyx_22050243_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_misalign,
  output logic        data_r_en,
  output logic        data_w_en,
  output logic [7:0]  data_wmask,
  output logic [63:0] data_addr,
  output logic [63:0] data_w,
  input  logic [63:0] data_r
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_NONE2 = 2'b11
  } op_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] result_q, result_d;
  logic        wen_q, wen_d;
  logic        misalign_q, misalign_d;

  logic        in_is_mem;
  logic        in_mis;
  logic [2:0]  off;
  logic [5:0]  shamt;
  logic [7:0]  size_mask;
  logic [63:0] rdata_sh;
  logic [63:0] load_val;

  // Alignment is judged on the incoming request so a misaligned access never reaches ACCESS.
  always_comb begin
    in_is_mem = (in_op == OP_LOAD) || (in_op == OP_STORE);
    case (in_funct3[1:0])
      2'b00:   in_mis = 1'b0;
      2'b01:   in_mis = in_addr[0];
      2'b10:   in_mis = |in_addr[1:0];
      default: in_mis = |in_addr[2:0];
    endcase
  end

  always_comb begin
    off      = addr_q[2:0];
    shamt    = {off, 3'b000};
    rdata_sh = data_r >> shamt;
    case (funct3_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    case (funct3_q)
      3'b000:  load_val = {{56{rdata_sh[7]}},  rdata_sh[7:0]};
      3'b001:  load_val = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b010:  load_val = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      3'b100:  load_val = {56'd0, rdata_sh[7:0]};
      3'b101:  load_val = {48'd0, rdata_sh[15:0]};
      3'b110:  load_val = {32'd0, rdata_sh[31:0]};
      default: load_val = rdata_sh;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    result_d   = result_q;
    wen_d      = wen_q;
    misalign_d = misalign_q;
    in_ready   = (state_q == IDLE) && !rst;
    out_valid  = 1'b0;
    data_r_en  = 1'b0;
    data_w_en  = 1'b0;
    data_wmask = '0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d     = in_op;
          funct3_d = in_funct3;
          addr_d   = in_addr;
          wdata_d  = in_wdata;
          rd_d     = in_rd;
          if (in_is_mem && !in_mis) begin
            state_d    = ACCESS;
            result_d   = '0;
            wen_d      = (in_op == OP_LOAD);
            misalign_d = 1'b0;
          end else begin
            state_d    = RESP;
            result_d   = in_is_mem ? '0 : in_addr;
            wen_d      = !in_is_mem;
            misalign_d = in_is_mem;
          end
        end
      end
      ACCESS: begin
        // Strobes are masked by rst so an aborted access never touches memory.
        data_r_en  = (op_q == OP_LOAD) && !rst;
        data_w_en  = (op_q == OP_STORE) && !rst;
        data_wmask = data_w_en ? (size_mask << off) : '0;
        if (op_q == OP_LOAD) begin
          result_d = load_val;
        end
        state_d = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      result_q   <= '0;
      wen_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      wen_q      <= wen_d;
      misalign_q <= misalign_d;
    end
  end

  assign data_addr    = {addr_q[63:3], 3'b000};
  assign data_w       = wdata_q << shamt;
  assign out_result   = result_q;
  assign out_rd       = rd_q;
  assign out_wen      = wen_q;
  assign out_misalign = misalign_q;

endmodule

// File: doc/ysyx_22050243_lsu.md
YSYX_22050243_LSU -- requirements
Module: ysyx_22050243_lsu

Interface
REQ-001 Parameters: none; all datapaths SHALL be 64-bit (RV64).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 in_valid  in  1  EXU request valid.
REQ-005 in_ready  out  1  LSU can accept a request.
REQ-006 in_op  in  2  00 none (pass-through), 01 load, 10 store, 11 treated as none.
REQ-007 in_funct3  in  3  RV64 width/sign code (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD).
REQ-008 in_addr  in  64  effective address, or the ALU result when in_op=none.
REQ-009 in_wdata  in  64  store data, right-aligned.
REQ-010 in_rd  in  5  destination register index.
REQ-011 out_valid  out  1  WBU result valid.
REQ-012 out_ready  in  1  WBU accepts the result.
REQ-013 out_result  out  64  load data or pass-through value.
REQ-014 out_rd / out_wen  out  5 / 1  writeback index and enable (1 for load and none, 0 for store).
REQ-015 out_misalign  out  1  access not naturally aligned.
REQ-016 data_r_en, data_w_en  out  1 each  memory read/write strobes.
REQ-017 data_wmask  out  8  byte-lane write mask.
REQ-018 data_addr  out  64  memory address, low 3 bits forced to 0.
REQ-019 data_w  out  64  lane-shifted write data.
REQ-020 data_r  in  64  memory read data, combinationally valid while data_r_en=1.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-022 in_ready SHALL be 1 only in IDLE with rst=0.
REQ-023 IDLE: on in_valid & in_ready, latch op/funct3/addr/wdata/rd; load/store without misalignment -> ACCESS; none or misaligned -> RESP.
REQ-024 ACCESS SHALL last exactly one cycle, with data_r_en=1 (load) or data_w_en=1 (store) for that single cycle only, then go to RESP.
REQ-025 Outside ACCESS, data_r_en, data_w_en, and data_wmask SHALL be 0.
REQ-026 Lane offset off = addr[2:0]; data_wmask = {SB:0x01, SH:0x03, SW:0x0F, SD:0xFF} << off; data_w = wdata << (8*off).
REQ-027 A load SHALL capture (data_r >> 8*off) at the end of ACCESS, truncate it to the access width, and sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU); LD SHALL pass through unchanged.
REQ-028 Misaligned means H with off[0]≠0, W with off[1:0]≠0, or D with off≠0; such an access SHALL issue no strobe and SHALL return out_misalign=1, out_result=0, out_wen=0.
REQ-029 Pass-through SHALL return out_result = latched in_addr.
REQ-030 A store SHALL return out_result=0.
REQ-031 RESP: out_valid=1 with out_* stable until out_valid & out_ready, then IDLE; out_valid SHALL be 0 in the following cycle.
REQ-032 Request-to-out_valid latency SHALL be 2 cycles for a memory access and 1 cycle for none/misaligned.
REQ-033 There SHALL be no back-to-back acceptance: a new request is accepted only in IDLE.
REQ-034 Back-pressure in RESP SHALL never re-issue memory strobes.

Reset
REQ-035 While rst=1 at a clock edge: state=IDLE, out_valid=0, out_result=0, out_rd=0, out_wen=0, out_misalign=0, and all latched request fields=0.
REQ-036 Reset asserted during ACCESS or RESP SHALL abort the operation; no strobe SHALL be asserted in the cycle after reset, and the pending result SHALL be discarded.

Verification
REQ-037 LB at addr 0x80000003, data_r=0x00000000_80FF0000 -> data_addr=0x80000000, data_r_en=1 for one cycle, out_result=0xFFFFFFFF_FFFFFF80 two cycles after acceptance, out_wen=1.
REQ-038 SH at addr 0x80000006, wdata=0x1234 -> data_wmask=0xC0, data_w=0x1234_0000_0000_0000, data_w_en=1 for exactly one cycle, out_wen=0.
REQ-039 LW at addr 0x80000002 -> no strobe, out_misalign=1, out_result=0, out_valid one cycle after acceptance.
REQ-040 out_ready held 0 for 5 cycles in RESP -> out_valid and out_result stable, in_ready=0, no strobes; out_ready=1 -> IDLE on the next edge.
REQ-041 rst pulsed during ACCESS of an SD -> next cycle IDLE, out_valid=0, data_w_en=0, in_ready=1 once rst is released.
REQ-042 in_op=none, in_addr=0xDEADBEEF, rd=5 -> out_result=0xDEADBEEF, out_rd=5, out_wen=1, no strobes.
